rapid_mem_arbiter: RTL and testbench
====================================

# rapid_mem_arbiter

Two-port to one-port main-memory arbiter for the rapid_x core. Port 1 (instruction fetch) and port 2 (data memory stage) share a single main-memory channel through this block. It allows one outstanding transaction at a time and grants the ports round-robin. A per-transaction watchdog returns an error completion if memory stalls. It sits between the CPU's two memory ports and the memory controller.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- TIMEOUT, 1023, cycles allowed in REQ+WAIT before error completion; 0 disables the watchdog

Ports (pN = p1 or p2, identical sets):
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_pN_valid  in  1  request pending; held with stable fields until o_pN_done
- i_pN_addr  in  ADDR_W  byte address
- i_pN_we  in  1  1 = write, 0 = read
- i_pN_wdata  in  DATA_W  write data
- i_pN_wstrb  in  DATA_W/8  byte enables for writes
- o_pN_done  out  1  one-cycle completion pulse
- o_pN_rdata  out  DATA_W  read data; valid while o_pN_done is high, 0 otherwise
- o_pN_err  out  1  timeout flag; qualified by o_pN_done
- o_mem_valid  out  1  downstream request valid
- o_mem_addr / o_mem_we / o_mem_wdata / o_mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  latched copy of the granted request
- i_mem_ready  in  1  downstream accepts the request when o_mem_valid && i_mem_ready
- i_mem_rvalid  in  1  completion from memory; given for both reads and writes
- i_mem_rdata  in  DATA_W  read data, qualified by i_mem_rvalid
- o_busy  out  1  state != IDLE
- o_grant  out  2  one-hot owner of the current transaction ([0]=p1, [1]=p2); 0 in IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE: if any i_pN_valid is high, select a winner:
  - single requester: that port wins;
  - both requesting: the port not granted last wins;
  - latch the winner's addr/we/wdata/wstrb, set o_grant, update last_grant, clear the timer, go to REQ.
- REQ: hold o_mem_valid=1 with the latched fields.
  - On i_mem_ready, drop o_mem_valid and go to WAIT.
  - If i_mem_rvalid arrives in the same cycle as i_mem_ready, it is ignored. Memory must respond at the earliest one cycle after acceptance.
- WAIT: on i_mem_rvalid, capture i_mem_rdata (capture 0 for writes), set err=0, go to DONE.
- DONE: assert o_pN_done for the granted port for one cycle, with rdata and err. Then go to IDLE and clear o_grant.
- Watchdog:
  - the timer increments each cycle in REQ and WAIT;
  - when it equals TIMEOUT (and TIMEOUT != 0), go to DONE with err=1 and rdata=0, and drop o_mem_valid.
  - In REQ, i_mem_ready takes precedence over the watchdog in the same cycle.
  - In WAIT, i_mem_rvalid takes precedence over the watchdog in the same cycle.
- i_mem_rvalid outside WAIT is ignored; this covers stray or late responses after a timeout.
- The requester must deassert valid, or present a new request, in the cycle after o_pN_done. Anything high in that cycle is treated as a new request.
- Non-granted request inputs are not sampled; the losing port simply waits.
- Timer width: clog2(TIMEOUT+1) bits. It never wraps, because the FSM leaves REQ/WAIT on reaching TIMEOUT.

## Timing
- Reset (i_reset=0, asynchronous):
  - state=IDLE, last_grant=p1 (so the first tie goes to p2), timer=0;
  - every output 0: o_mem_valid, o_mem_addr/we/wdata/wstrb, o_pN_done, o_pN_rdata, o_pN_err, o_busy, o_grant.
- Reset asserted mid-transaction aborts immediately: no done pulse, and any later rvalid is ignored.
- Latency, with the request seen in IDLE at cycle N:
  - o_mem_valid high in cycle N+1;
  - if i_mem_ready arrives in cycle N+1+a and i_mem_rvalid in cycle R, o_pN_done is high in cycle R+1;
  - minimum request-to-done latency is 4 cycles (a=0, R=N+2).
- Back-to-back: one idle arbitration cycle after DONE, so the next o_mem_valid appears 2 cycles after the done pulse.
- Throughput: one transaction per (4 + memory wait) cycles maximum.

## Test plan
- Single p1 read, addr 0x100, i_mem_ready=1 immediately, rdata 0xDEADBEEF one cycle after acceptance -> o_mem_valid in cycle N+1, o_p1_done pulses once with o_p1_rdata=0xDEADBEEF and o_p1_err=0; p2 outputs stay 0.
- p1 and p2 both request from reset -> p2 granted first (o_grant=2'b10), then p1. With both held continuously, grants alternate p2, p1, p2, p1.
- p2 write, wdata 0x12345678, wstrb 4'b0011, i_mem_ready delayed 3 cycles -> o_mem_valid and the fields stay stable for 4 cycles; done arrives after rvalid with rdata=0.
- TIMEOUT=8, memory never asserts ready -> o_p1_done with o_p1_err=1 and rdata=0 at cycle N+10 (timer hits 8 in REQ); a later stray i_mem_rvalid produces no done.
- i_reset pulled low while in WAIT -> all outputs 0 asynchronously, FSM in IDLE; the subsequent i_mem_rvalid is ignored, and a new p1 request completes normally.
- i_mem_rvalid in the same cycle as TIMEOUT expiry in WAIT -> normal completion with err=0 and the captured rdata.

Source files
------------

// File: rtl/rapid_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rapid_mem_arbiter
// Description : Two-port to one-port main-memory arbiter for the rapid_x core.
//               Port 1 (instruction fetch) and port 2 (data stage) share one
//               memory channel. One transaction is in flight at a time, and
//               the ports are granted round-robin. A per-transaction watchdog
//               produces an error completion if memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module rapid_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_reset,

  // Port 1: instruction fetch
  input  logic                  i_p1_valid,
  input  logic [ADDR_W-1:0]     i_p1_addr,
  input  logic                  i_p1_we,
  input  logic [DATA_W-1:0]     i_p1_wdata,
  input  logic [DATA_W/8-1:0]   i_p1_wstrb,
  output logic                  o_p1_done,
  output logic [DATA_W-1:0]     o_p1_rdata,
  output logic                  o_p1_err,

  // Port 2: data memory stage
  input  logic                  i_p2_valid,
  input  logic [ADDR_W-1:0]     i_p2_addr,
  input  logic                  i_p2_we,
  input  logic [DATA_W-1:0]     i_p2_wdata,
  input  logic [DATA_W/8-1:0]   i_p2_wstrb,
  output logic                  o_p2_done,
  output logic [DATA_W-1:0]     o_p2_rdata,
  output logic                  o_p2_err,

  // Main-memory channel
  output logic                  o_mem_valid,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata,

  // Status
  output logic                  o_busy,
  output logic [1:0]            o_grant
);

  // Timer holds 0..TIMEOUT; a disabled watchdog still needs a 1-bit vector.
  localparam int                   c_TIMER_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMEOUT_VAL = c_TIMER_W'(TIMEOUT);
  localparam bit                   c_WDOG_EN     = (TIMEOUT != 0);
  localparam logic [c_TIMER_W-1:0] c_TIMER_ONE   = c_TIMER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_last_grant;   // 0 = p1 granted last, 1 = p2
  logic [c_TIMER_W-1:0]   r_timer;

  logic                   w_any_req;
  logic                   w_pick_p2;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic                   w_sel_we;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic [DATA_W/8-1:0]    w_sel_wstrb;
  logic                   w_timer_expired;
  logic                   w_finish;
  logic                   w_fin_err;
  logic [DATA_W-1:0]      w_fin_rdata;

  // Round-robin winner: a lone requester wins, a tie goes to the port not
  // granted last. Only the winner's fields are forwarded.
  always_comb begin
    w_any_req   = i_p1_valid | i_p2_valid;
    w_pick_p2   = i_p2_valid & (~i_p1_valid | ~r_last_grant);
    w_sel_addr  = w_pick_p2 ? i_p2_addr  : i_p1_addr;
    w_sel_we    = w_pick_p2 ? i_p2_we    : i_p1_we;
    w_sel_wdata = w_pick_p2 ? i_p2_wdata : i_p1_wdata;
    w_sel_wstrb = w_pick_p2 ? i_p2_wstrb : i_p1_wstrb;
  end

  // Completion decision for the current cycle. Memory handshakes win over
  // the watchdog when both land together; writes always return zero data.
  always_comb begin
    w_timer_expired = c_WDOG_EN && (r_timer == c_TIMEOUT_VAL);
    w_finish        = 1'b0;
    w_fin_err       = 1'b0;
    w_fin_rdata     = '0;
    case (r_state)
      S_REQ: begin
        if (!i_mem_ready && w_timer_expired) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          w_finish    = 1'b1;
          w_fin_rdata = o_mem_we ? '0 : i_mem_rdata;
        end else if (w_timer_expired) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM with all outputs registered. Reset aborts any transaction
  // in flight without a completion pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b0;
      r_timer      <= '0;
      o_mem_valid  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
      o_mem_wstrb  <= '0;
      o_p1_done    <= 1'b0;
      o_p1_rdata   <= '0;
      o_p1_err     <= 1'b0;
      o_p2_done    <= 1'b0;
      o_p2_rdata   <= '0;
      o_p2_err     <= 1'b0;
      o_busy       <= 1'b0;
      o_grant      <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            o_mem_addr   <= w_sel_addr;
            o_mem_we     <= w_sel_we;
            o_mem_wdata  <= w_sel_wdata;
            o_mem_wstrb  <= w_sel_wstrb;
            o_mem_valid  <= 1'b1;
            o_grant      <= w_pick_p2 ? 2'b10 : 2'b01;
            r_last_grant <= w_pick_p2;
            r_timer      <= '0;
            o_busy       <= 1'b1;
            r_state      <= S_REQ;
          end
        end

        S_REQ, S_WAIT: begin
          if (w_finish) begin
            o_mem_valid <= 1'b0;
            if (o_grant[1]) begin
              o_p2_done  <= 1'b1;
              o_p2_rdata <= w_fin_rdata;
              o_p2_err   <= w_fin_err;
            end else begin
              o_p1_done  <= 1'b1;
              o_p1_rdata <= w_fin_rdata;
              o_p1_err   <= w_fin_err;
            end
            r_state <= S_DONE;
          end else begin
            if (c_WDOG_EN) begin
              r_timer <= r_timer + c_TIMER_ONE;
            end
            if (r_state == S_REQ && i_mem_ready) begin
              o_mem_valid <= 1'b0;
              r_state     <= S_WAIT;
            end
          end
        end

        S_DONE: begin
          o_p1_done  <= 1'b0;
          o_p1_rdata <= '0;
          o_p1_err   <= 1'b0;
          o_p2_done  <= 1'b0;
          o_p2_rdata <= '0;
          o_p2_err   <= 1'b0;
          o_grant    <= 2'b00;
          o_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rapid_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rapid_mem_arbiter
// Description : Directed bench for rapid_mem_arbiter with a reactive memory
//               model and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rapid_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_p1_valid, i_p1_we, i_p2_valid, i_p2_we;
  logic [31:0]       i_p1_addr, i_p1_wdata, i_p2_addr, i_p2_wdata;
  logic [3:0]        i_p1_wstrb, i_p2_wstrb;
  logic              o_p1_done, o_p1_err, o_p2_done, o_p2_err;
  logic [31:0]       o_p1_rdata, o_p2_rdata;
  logic              o_mem_valid, o_mem_we;
  logic [31:0]       o_mem_addr, o_mem_wdata;
  logic [3:0]        o_mem_wstrb;
  logic              i_mem_ready, i_mem_rvalid;
  logic [31:0]       i_mem_rdata;
  logic              o_busy;
  logic [1:0]        o_grant;

  rapid_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_p1_valid(i_p1_valid), .i_p1_addr(i_p1_addr), .i_p1_we(i_p1_we),
    .i_p1_wdata(i_p1_wdata), .i_p1_wstrb(i_p1_wstrb),
    .o_p1_done(o_p1_done), .o_p1_rdata(o_p1_rdata), .o_p1_err(o_p1_err),
    .i_p2_valid(i_p2_valid), .i_p2_addr(i_p2_addr), .i_p2_we(i_p2_we),
    .i_p2_wdata(i_p2_wdata), .i_p2_wstrb(i_p2_wstrb),
    .o_p2_done(o_p2_done), .o_p2_rdata(o_p2_rdata), .o_p2_err(o_p2_err),
    .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Memory model controls and state
  bit          mem_auto     = 1'b1;
  int          ready_delay  = 0;
  int          resp_delay   = 0;
  bit          stray_rvalid = 1'b0;
  bit          acc_pending  = 1'b0;
  int          rdy_cnt      = 0;
  int          resp_cnt     = 0;
  logic [31:0] acc_addr;
  logic        acc_we;

  function automatic logic [31:0] mem_rdata(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_side"},
        128'({o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb, o_busy, o_grant}), 128'd0);
    chk({tag, "_port_side"},
        128'({o_p1_done, o_p1_rdata, o_p1_err, o_p2_done, o_p2_rdata, o_p2_err}), 128'd0);
  endtask

  // One memory-side cycle: accept after ready_delay, respond resp_delay
  // cycles after the cycle following acceptance.
  task automatic mem_step();
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    if (stray_rvalid) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hBAD0BAD0;
      stray_rvalid = 1'b0;
    end else if (acc_pending) begin
      if (resp_cnt >= resp_delay) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = acc_we ? 32'hFFFF_FFFF : mem_rdata(acc_addr);
        acc_pending  = 1'b0;
      end else begin
        resp_cnt++;
      end
    end else if (mem_auto && o_mem_valid) begin
      if (rdy_cnt >= ready_delay) begin
        i_mem_ready = 1'b1;
        acc_pending = 1'b1;
        acc_addr    = o_mem_addr;
        acc_we      = o_mem_we;
        resp_cnt    = 0;
        rdy_cnt     = 0;
      end else begin
        rdy_cnt++;
      end
    end
  endtask

  // Advance one clock, score any completion, then update memory inputs.
  task automatic cycle();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (o_p1_done || o_p2_done) begin
      chk("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_port",  128'({o_p2_done, o_p1_done}), 128'(e.port));
        chk("done_rdata", 128'(e.port[1] ? o_p2_rdata : o_p1_rdata), 128'(e.rdata));
        chk("done_err",   128'(e.port[1] ? o_p2_err : o_p1_err), 128'(e.err));
      end
    end else begin
      chk("rdata_zero_when_idle", 128'({o_p1_rdata, o_p2_rdata}), 128'd0);
    end
    mem_step();
  endtask

  task automatic run_single(input bit p2, input logic [31:0] addr, input logic we,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] exp_rd, input logic exp_err, input int bound);
    int n;
    exp_q.push_back('{p2 ? 2'b10 : 2'b01, exp_rd, exp_err});
    if (p2) begin
      i_p2_valid = 1'b1; i_p2_addr = addr; i_p2_we = we; i_p2_wdata = wd; i_p2_wstrb = ws;
    end else begin
      i_p1_valid = 1'b1; i_p1_addr = addr; i_p1_we = we; i_p1_wdata = wd; i_p1_wstrb = ws;
    end
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    chk("done_within_bound", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    i_p1_valid = 1'b0;
    i_p2_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int n_done;
    int guard;
    i_reset    = 1'b0;
    i_p1_valid = 1'b0; i_p1_addr = '0; i_p1_we = 1'b0; i_p1_wdata = '0; i_p1_wstrb = '0;
    i_p2_valid = 1'b0; i_p2_addr = '0; i_p2_we = 1'b0; i_p2_wdata = '0; i_p2_wstrb = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_reset = 1'b1;
    cycle();
    cycle();

    // Single p1 read, ready immediately, response one cycle after acceptance
    exp_q.push_back('{2'b01, 32'hDEADBEEF, 1'b0});
    i_p1_valid = 1'b1; i_p1_addr = 32'h100; i_p1_we = 1'b0;
    cycle();
    chk("t1_mem_valid_n1", 128'(o_mem_valid), 128'd1);
    chk("t1_mem_addr", 128'(o_mem_addr), 128'h100);
    chk("t1_grant_p1", 128'(o_grant), 128'b01);
    cycle();
    chk("t1_mem_valid_n2", 128'(o_mem_valid), 128'd0);
    cycle();
    chk("t1_done_n3", 128'(o_p1_done), 128'd1);
    chk("t1_p2_quiet", 128'({o_p2_done, o_p2_rdata, o_p2_err}), 128'd0);
    chk("t1_sb_drained", 128'(exp_q.size()), 128'd0);
    i_p1_valid = 1'b0;
    cycle();
    chk("t1_back_idle", 128'({o_busy, o_grant, o_p1_done}), 128'd0);

    // Both ports held: p2 wins the first tie, then grants alternate
    exp_q.push_back('{2'b10, mem_rdata(32'h300), 1'b0});
    exp_q.push_back('{2'b01, mem_rdata(32'h200), 1'b0});
    exp_q.push_back('{2'b10, mem_rdata(32'h300), 1'b0});
    exp_q.push_back('{2'b01, mem_rdata(32'h200), 1'b0});
    i_p1_valid = 1'b1; i_p1_addr = 32'h200; i_p1_we = 1'b0;
    i_p2_valid = 1'b1; i_p2_addr = 32'h300; i_p2_we = 1'b0;
    cycle();
    chk("t2_first_grant_p2", 128'(o_grant), 128'b10);
    n_done = 0;
    guard  = 0;
    while (n_done < 4 && guard < 60) begin
      cycle();
      guard++;
      if (o_p1_done || o_p2_done) n_done++;
    end
    i_p1_valid = 1'b0;
    i_p2_valid = 1'b0;
    chk("t2_four_done", 128'(n_done), 128'd4);
    chk("t2_sb_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    cycle();
    cycle();

    // p2 write with ready delayed 3 cycles: request held stable 4 cycles
    ready_delay = 3;
    exp_q.push_back('{2'b10, 32'h0, 1'b0});
    i_p2_valid = 1'b1; i_p2_addr = 32'h40; i_p2_we = 1'b1;
    i_p2_wdata = 32'h12345678; i_p2_wstrb = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_mem_hold",
          128'({o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb}),
          128'({1'b1, 32'h40, 1'b1, 32'h12345678, 4'b0011}));
    end
    cycle();
    chk("t3_mem_released", 128'(o_mem_valid), 128'd0);
    cycle();
    chk("t3_done", 128'(o_p2_done), 128'd1);
    i_p2_valid  = 1'b0;
    ready_delay = 0;
    cycle();

    // Watchdog: memory never ready, error completion at N+10
    mem_auto = 1'b0;
    exp_q.push_back('{2'b01, 32'h0, 1'b1});
    i_p1_valid = 1'b1; i_p1_addr = 32'h500; i_p1_we = 1'b0;
    repeat (9) cycle();
    chk("t4_no_early_done", 128'({o_p1_done, o_mem_valid}), 128'b01);
    cycle();
    chk("t4_done_n10", 128'({o_p1_done, o_p1_err, o_mem_valid}), 128'b110);
    i_p1_valid = 1'b0;
    mem_auto   = 1'b1;
    cycle();
    stray_rvalid = 1'b1;
    repeat (4) cycle();
    chk("t4_stray_ignored", 128'({o_busy, o_p1_done, o_p2_done}), 128'd0);
    chk("t4_sb_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();

    // Reset asserted while in WAIT: async clear, late rvalid ignored
    resp_delay = 5;
    i_p1_valid = 1'b1; i_p1_addr = 32'h600; i_p1_we = 1'b0;
    cycle();
    cycle();
    chk("t5_in_wait", 128'({o_busy, o_mem_valid}), 128'b10);
    #2;
    i_reset = 1'b0;
    #1;
    check_all_zero("t5_async");
    i_p1_valid = 1'b0;
    cycle();
    cycle();
    i_reset = 1'b1;
    repeat (8) cycle();
    chk("t5_no_done_after_reset", 128'({o_busy, o_grant}), 128'd0);
    resp_delay = 0;
    run_single(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 10);
    cycle();

    // rvalid in the same WAIT cycle the watchdog expires: normal completion
    resp_delay = 7;
    exp_q.push_back('{2'b01, mem_rdata(32'h700), 1'b0});
    i_p1_valid = 1'b1; i_p1_addr = 32'h700; i_p1_we = 1'b0;
    repeat (9) cycle();
    cycle();
    chk("t6_done_n10", 128'({o_p1_done, o_p1_err}), 128'b10);
    i_p1_valid = 1'b0;
    resp_delay = 0;
    cycle();
    chk("t6_sb_drained", 128'(exp_q.size()), 128'd0);

    // p2 read after the others, checks last_grant bookkeeping with one requester
    run_single(1'b1, 32'h884, 1'b0, 32'h0, 4'h0, mem_rdata(32'h884), 1'b0, 10);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
